id_exe_stage_reg: RTL and testbench

- Pipeline register between the ID datapath and the EXE stage.
- Latches the decoded instruction fields, the register-file read data and the branch-prediction bits each cycle, then presents them to EXE.
- Detects load-use hazards and injects bubbles on flush or hazard.
- Bypasses same-cycle WB writes into the captured operands, because the ID register file does not forward internally.
- Exports a saturating bubble counter for performance monitoring.

---
 rtl/id_exe_stage_reg.sv | 204 ++++++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: captures decoded fields and operands, injects bubbles on
// flush or load-use hazard, bypasses same-cycle WB writes and counts inserted bubbles.
module id_exe_stage_reg #(
    parameter int PRED_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [159:0]      in_imm,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_rs1_data,
    input  logic [31:0]       in_rs2_data,
    input  logic              in_prediction,
    input  logic [PRED_W-1:0] in_all_prediction,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [159:0]      out_imm,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_rs1_data,
    output logic [31:0]       out_rs2_data,
    output logic              out_prediction,
    output logic [PRED_W-1:0] out_all_prediction,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_NOP    = 7'h13;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              r_valid;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [159:0]      r_imm;
    logic [31:0]       r_pc;
    logic [31:0]       r_rs1_data;
    logic [31:0]       r_rs2_data;
    logic              r_prediction;
    logic [PRED_W-1:0] r_all_prediction;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_nxt_valid;
    logic [6:0]        w_nxt_opcode;
    logic [2:0]        w_nxt_funct3;
    logic [6:0]        w_nxt_funct7;
    logic [4:0]        w_nxt_rs1;
    logic [4:0]        w_nxt_rs2;
    logic [4:0]        w_nxt_rd;
    logic [159:0]      w_nxt_imm;
    logic [31:0]       w_nxt_pc;
    logic [31:0]       w_nxt_rs1_data;
    logic [31:0]       w_nxt_rs2_data;
    logic              w_nxt_prediction;
    logic [PRED_W-1:0] w_nxt_all_prediction;

    logic w_rs1_used;
    logic w_rs2_used;
    logic w_hazard;
    logic w_bubble;
    logic w_count;

    assign w_rs2_used = (in_opcode == OPC_OP) || (in_opcode == OPC_STORE) ||
                        (in_opcode == OPC_BRANCH);
    assign w_rs1_used = !((in_opcode == OPC_LUI) || (in_opcode == OPC_AUIPC) ||
                          (in_opcode == OPC_JAL));

    assign w_hazard = in_valid && !flush && r_valid && (r_opcode == OPC_LOAD) &&
                      (r_rd != 5'd0) &&
                      ((w_rs1_used && (in_rs1 == r_rd)) || (w_rs2_used && (in_rs2 == r_rd)));

    // Non-counting bubbles (empty ID slot) share the bubble path but not the counter.
    assign w_bubble = flush || (!stall && (w_hazard || !in_valid));
    assign w_count  = flush || (!stall && w_hazard);

    always_comb begin
        w_nxt_valid          = r_valid;
        w_nxt_opcode         = r_opcode;
        w_nxt_funct3         = r_funct3;
        w_nxt_funct7         = r_funct7;
        w_nxt_rs1            = r_rs1;
        w_nxt_rs2            = r_rs2;
        w_nxt_rd             = r_rd;
        w_nxt_imm            = r_imm;
        w_nxt_pc             = r_pc;
        w_nxt_rs1_data       = r_rs1_data;
        w_nxt_rs2_data       = r_rs2_data;
        w_nxt_prediction     = r_prediction;
        w_nxt_all_prediction = r_all_prediction;
        if (w_bubble) begin
            w_nxt_valid          = 1'b0;
            w_nxt_opcode         = OPC_NOP;
            w_nxt_funct3         = '0;
            w_nxt_funct7         = '0;
            w_nxt_rs1            = '0;
            w_nxt_rs2            = '0;
            w_nxt_rd             = '0;
            w_nxt_imm            = '0;
            w_nxt_pc             = '0;
            w_nxt_rs1_data       = '0;
            w_nxt_rs2_data       = '0;
            w_nxt_prediction     = 1'b0;
            w_nxt_all_prediction = '0;
        end else if (stall) begin
            // Held operands must still observe WB writes or they go stale.
            if (wb_en && (wb_rd != 5'd0) && (wb_rd == r_rs1)) w_nxt_rs1_data = wb_data;
            if (wb_en && (wb_rd != 5'd0) && (wb_rd == r_rs2)) w_nxt_rs2_data = wb_data;
        end else begin
            w_nxt_valid          = 1'b1;
            w_nxt_opcode         = in_opcode;
            w_nxt_funct3         = in_funct3;
            w_nxt_funct7         = in_funct7;
            w_nxt_rs1            = in_rs1;
            w_nxt_rs2            = in_rs2;
            w_nxt_rd             = in_rd;
            w_nxt_imm            = in_imm;
            w_nxt_pc             = in_pc;
            w_nxt_prediction     = in_prediction;
            w_nxt_all_prediction = in_all_prediction;
            w_nxt_rs1_data = (wb_en && (wb_rd != 5'd0) && (wb_rd == in_rs1)) ? wb_data : in_rs1_data;
            w_nxt_rs2_data = (wb_en && (wb_rd != 5'd0) && (wb_rd == in_rs2)) ? wb_data : in_rs2_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid          <= 1'b0;
            r_opcode         <= '0;
            r_funct3         <= '0;
            r_funct7         <= '0;
            r_rs1            <= '0;
            r_rs2            <= '0;
            r_rd             <= '0;
            r_imm            <= '0;
            r_pc             <= '0;
            r_rs1_data       <= '0;
            r_rs2_data       <= '0;
            r_prediction     <= 1'b0;
            r_all_prediction <= '0;
            r_bubble_count   <= '0;
        end else begin
            r_valid          <= w_nxt_valid;
            r_opcode         <= w_nxt_opcode;
            r_funct3         <= w_nxt_funct3;
            r_funct7         <= w_nxt_funct7;
            r_rs1            <= w_nxt_rs1;
            r_rs2            <= w_nxt_rs2;
            r_rd             <= w_nxt_rd;
            r_imm            <= w_nxt_imm;
            r_pc             <= w_nxt_pc;
            r_rs1_data       <= w_nxt_rs1_data;
            r_rs2_data       <= w_nxt_rs2_data;
            r_prediction     <= w_nxt_prediction;
            r_all_prediction <= w_nxt_all_prediction;
            if (w_count) r_bubble_count <= sat_inc(r_bubble_count);
        end
    end

    assign out_valid          = r_valid;
    assign out_opcode         = r_opcode;
    assign out_funct3         = r_funct3;
    assign out_funct7         = r_funct7;
    assign out_rs1            = r_rs1;
    assign out_rs2            = r_rs2;
    assign out_rd             = r_rd;
    assign out_imm            = r_imm;
    assign out_pc             = r_pc;
    assign out_rs1_data       = r_rs1_data;
    assign out_rs2_data       = r_rs2_data;
    assign out_prediction     = r_prediction;
    assign out_all_prediction = r_all_prediction;
    assign hazard_stall       = w_hazard;
    assign bubble_count       = r_bubble_count;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Randomised bench for id_exe_stage_reg: a rule-level model is compared every cycle
// against a default instance and a 4-bit-counter instance, plus literal checks.
module tb_id_exe_stage_reg;
    localparam int PRED_W = 2;
    localparam int VW = 292;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid, in_prediction, wb_en, stall, flush;
    logic [6:0]        in_opcode, in_funct7;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rs1, in_rs2, in_rd, wb_rd;
    logic [159:0]      in_imm;
    logic [31:0]       in_pc, in_rs1_data, in_rs2_data, wb_data;
    logic [PRED_W-1:0] in_all_prediction;

    logic              d_valid, d_pred, d_haz, s_valid, s_pred, s_haz;
    logic [6:0]        d_opcode, d_funct7, s_opcode, s_funct7;
    logic [2:0]        d_funct3, s_funct3;
    logic [4:0]        d_rs1, d_rs2, d_rd, s_rs1, s_rs2, s_rd;
    logic [159:0]      d_imm, s_imm;
    logic [31:0]       d_pc, d_d1, d_d2, s_pc, s_d1, s_d2;
    logic [PRED_W-1:0] d_allp, s_allp;
    logic [15:0]       d_cnt;
    logic [3:0]        s_cnt;

    id_exe_stage_reg #(.PRED_W(PRED_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_prediction(in_prediction), .in_all_prediction(in_all_prediction), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .flush(flush),
        .out_valid(d_valid), .out_opcode(d_opcode), .out_funct3(d_funct3), .out_funct7(d_funct7),
        .out_rs1(d_rs1), .out_rs2(d_rs2), .out_rd(d_rd), .out_imm(d_imm), .out_pc(d_pc),
        .out_rs1_data(d_d1), .out_rs2_data(d_d2), .out_prediction(d_pred),
        .out_all_prediction(d_allp), .hazard_stall(d_haz), .bubble_count(d_cnt));

    id_exe_stage_reg #(.PRED_W(PRED_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_prediction(in_prediction), .in_all_prediction(in_all_prediction), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .flush(flush),
        .out_valid(s_valid), .out_opcode(s_opcode), .out_funct3(s_funct3), .out_funct7(s_funct7),
        .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd), .out_imm(s_imm), .out_pc(s_pc),
        .out_rs1_data(s_d1), .out_rs2_data(s_d2), .out_prediction(s_pred),
        .out_all_prediction(s_allp), .hazard_stall(s_haz), .bubble_count(s_cnt));

    wire [VW-1:0] d_vec = {d_valid, d_opcode, d_funct3, d_funct7, d_rs1, d_rs2, d_rd,
                           d_imm, d_pc, d_d1, d_d2, d_pred, d_allp};
    wire [VW-1:0] s_vec = {s_valid, s_opcode, s_funct3, s_funct7, s_rs1, s_rs2, s_rd,
                           s_imm, s_pc, s_d1, s_d2, s_pred, s_allp};

    // Reference model: contents of the EXE-side register and the total bubble count.
    logic              m_valid, m_pred;
    logic [6:0]        m_opcode, m_funct7;
    logic [2:0]        m_funct3;
    logic [4:0]        m_rs1, m_rs2, m_rd;
    logic [159:0]      m_imm;
    logic [31:0]       m_pc, m_d1, m_d2;
    logic [PRED_W-1:0] m_allp;
    int                m_cnt;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [VW-1:0] model_vec();
        return {m_valid, m_opcode, m_funct3, m_funct7, m_rs1, m_rs2, m_rd,
                m_imm, m_pc, m_d1, m_d2, m_pred, m_allp};
    endfunction

    task automatic model_clear(input logic [6:0] op);
        {m_valid, m_funct3, m_funct7, m_rs1, m_rs2, m_rd, m_imm, m_pc, m_d1, m_d2, m_pred, m_allp} = '0;
        m_opcode = op;
    endtask

    function automatic bit model_hazard();
        bit uses1 = !(in_opcode inside {7'h37, 7'h17, 7'h6f});
        bit uses2 = in_opcode inside {7'h33, 7'h23, 7'h63};
        return in_valid && !flush && m_valid && m_opcode == 7'h03 && m_rd != 0 &&
               ((uses1 && in_rs1 == m_rd) || (uses2 && in_rs2 == m_rd));
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        return (wb_en && wb_rd != 0 && wb_rd == idx) ? wb_data : rf;
    endfunction

    task automatic model_step();
        if (flush) begin
            model_clear(7'h13); m_cnt++;
        end else if (stall) begin
            m_d1 = fwd(m_rs1, m_d1);
            m_d2 = fwd(m_rs2, m_d2);
        end else if (model_hazard()) begin
            model_clear(7'h13); m_cnt++;
        end else if (!in_valid) begin
            model_clear(7'h13);
        end else begin
            m_valid = 1'b1; m_opcode = in_opcode; m_funct3 = in_funct3; m_funct7 = in_funct7;
            m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_imm = in_imm; m_pc = in_pc;
            m_d1 = fwd(in_rs1, in_rs1_data); m_d2 = fwd(in_rs2, in_rs2_data);
            m_pred = in_prediction; m_allp = in_all_prediction;
        end
    endtask

    task automatic compare_all();
        chk("fields", d_vec, model_vec());
        chk("count", d_cnt, (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt));
        chk("hazard", d_haz, model_hazard());
        chk("sat_fields", s_vec, model_vec());
        chk("sat_count", s_cnt, (m_cnt > 15) ? 4'hF : 4'(m_cnt));
        chk("sat_hazard", s_haz, model_hazard());
    endtask

    // Inputs are applied just after a rising edge; checks happen on the falling edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic [31:0] pc);
        in_valid = v; in_opcode = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_pc = pc;
        in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
        in_imm = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_rs1_data = $urandom; in_rs2_data = $urandom;
        in_prediction = 1'($urandom); in_all_prediction = PRED_W'($urandom);
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", d_valid, 0);
        chk("arst_count", d_cnt, 0);
        chk("arst_opcode", d_opcode, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear(7'h00); m_cnt = 0;
    endtask

    logic [6:0] ops [8] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h13};

    initial begin
        put(0, 7'h00, 0, 0, 0, 0);
        model_clear(7'h00); m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", d_valid, 0);
        chk("rst_count", d_cnt, 0);

        // Async reset while a valid ADD and a nonzero count are held
        put(1, 7'h33, 1, 2, 3, 32'h40); flush = 1'b1; cycle();
        put(1, 7'h33, 1, 2, 3, 32'h40); cycle();
        chk("pre_rst_valid", d_valid, 1);
        chk("pre_rst_count", d_cnt, 1);
        do_reset();
        put(1, 7'h33, 1, 2, 3, 32'h60); cycle();
        chk("post_rst_valid", d_valid, 1);
        chk("post_rst_pc", d_pc, 32'h60);
        chk("post_rst_rd", d_rd, 3);

        // Load-use: LW x5 then ADD x6,x5,x1
        put(1, 7'h03, 1, 0, 5, 32'h64); cycle();
        put(1, 7'h33, 5, 1, 6, 32'h68); #1;
        chk("lu_hazard", d_haz, 1);
        cycle();
        chk("lu_bubble_op", d_opcode, 7'h13);
        chk("lu_bubble_valid", d_valid, 0);
        chk("lu_count", d_cnt, 1);
        cycle();
        chk("lu_reload_valid", d_valid, 1);
        chk("lu_reload_rd", d_rd, 6);

        // No false hazards; SW uses rs2
        put(1, 7'h03, 1, 0, 0, 32'h70); cycle();
        put(1, 7'h33, 0, 1, 6, 32'h74); #1;
        chk("lw_x0_hazard", d_haz, 0);
        cycle();
        put(1, 7'h03, 1, 0, 7, 32'h78); cycle();
        put(1, 7'h37, 7, 7, 8, 32'h7c); #1;
        chk("lui_hazard", d_haz, 0);
        cycle();
        chk("lui_loaded", d_opcode, 7'h37);
        put(1, 7'h03, 1, 0, 9, 32'h80); cycle();
        put(1, 7'h23, 1, 9, 0, 32'h84); #1;
        chk("sw_hazard", d_haz, 1);
        cycle();
        cycle();
        chk("sw_loaded", d_opcode, 7'h23);

        // WB bypass into captured operand
        put(1, 7'h33, 4, 2, 3, 32'h88);
        in_rs1_data = 32'h11; wb_en = 1'b1; wb_rd = 4; wb_data = 32'hDEAD;
        cycle();
        chk("bypass_hit", d_d1, 32'hDEAD);
        put(1, 7'h33, 4, 2, 3, 32'h8c);
        in_rs1_data = 32'h11; wb_en = 1'b1; wb_rd = 0; wb_data = 32'hDEAD;
        cycle();
        chk("bypass_x0", d_d1, 32'h11);

        // Stall holds, refreshes rs2 from WB; flush beats stall
        put(1, 7'h33, 1, 2, 3, 32'h90); cycle();
        for (int i = 0; i < 3; i++) begin
            put(1, ops[$urandom % 8], 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
            stall = 1'b1;
            if (i == 2) begin wb_en = 1'b1; wb_rd = 2; wb_data = 32'hBEEF; end
            cycle();
            chk("stall_pc_hold", d_pc, 32'h90);
        end
        chk("stall_refresh", d_d2, 32'hBEEF);
        stall = 1'b1; flush = 1'b1; cycle();
        chk("flush_stall_valid", d_valid, 0);
        chk("flush_stall_count", d_cnt, 3);

        // Saturation of the 4-bit counter
        do_reset();
        put(1, 7'h33, 1, 2, 3, 32'ha0); flush = 1'b1;
        repeat (20) cycle();
        chk("sat_15", s_cnt, 15);
        chk("nosat_20", d_cnt, 20);
        cycle();
        chk("sat_hold", s_cnt, 15);

        // Random traffic with a small register pool to provoke hazards and bypasses
        for (int n = 0; n < 600; n++) begin
            put(($urandom % 8) != 0, ops[$urandom % 8], 5'($urandom % 4), 5'($urandom % 4),
                5'($urandom % 4), $urandom);
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 10) == 0;
            wb_en = 1'($urandom);
            wb_rd = 5'($urandom % 4);
            wb_data = $urandom;
            cycle();
        end
        @(negedge clk);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
